// File: rtl/reg_write_demux.sv
// Register write-back buffer: queues {addr,data} requests and retires one per cycle as a one-hot LOAD strobe plus DATA.
// Optional macro RF_WR_ZERO_PROTECT_EN: entries addressed to register 0 are consumed without strobing LOAD.
module reg_write_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         WR_VALID,
  output logic                         WR_READY,
  input  logic [ADDR_WIDTH-1:0]        WR_ADDR,
  input  logic [DATA_WIDTH-1:0]        WR_DATA,
  input  logic                         HOLD,
  output logic [(2**ADDR_WIDTH)-1:0]   LOAD,
  output logic [DATA_WIDTH-1:0]        DATA,
  output logic                         BUSY
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = 2**ADDR_WIDTH;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic                  push;
  logic                  pop;
  logic                  retire;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [LW-1:0]         load_next;
  logic [DATA_WIDTH-1:0] data_next;

  // Ready depends on occupancy alone, so a full buffer refuses even when a pop is pending.
  assign WR_READY  = (count != CNT_FULL);
  assign BUSY      = (count != '0);
  assign push      = WR_VALID && WR_READY;
  assign pop       = BUSY && !HOLD;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr] <= WR_ADDR;
      data_mem[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    load_next = '0;
    data_next = DATA;
    retire    = 1'b1;
`ifdef RF_WR_ZERO_PROTECT_EN
    if (head_addr == '0) retire = 1'b0;
`else
    retire    = 1'b1;
`endif
    if (retire) begin
      load_next[head_addr] = 1'b1;
      data_next            = head_data;
    end
  end

  // DATA keeps its last retired value; LOAD is a one-cycle strobe per retired entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      LOAD <= '0;
      DATA <= '0;
    end else if (pop) begin
      LOAD <= load_next;
      DATA <= data_next;
    end else begin
      LOAD <= '0;
    end
  end

endmodule

// File: tb/tb_reg_write_demux.sv
// Directed self-checking bench for reg_write_demux (default 32/5/2 configuration).
module tb_reg_write_demux;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WR_VALID;
  logic        WR_READY;
  logic [4:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        HOLD;
  logic [31:0] LOAD;
  logic [31:0] DATA;
  logic        BUSY;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] exp_load;
  logic [31:0] exp_data;

  reg_write_demux #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .DEPTH(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .WR_VALID(WR_VALID),
    .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .HOLD(HOLD),
    .LOAD(LOAD),
    .DATA(DATA),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0; HOLD = 1'b0;

    // 1: reset and idle
    #2;
    check("rst_load", LOAD, 0);
    check("rst_data", DATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ready", WR_READY, 1);
    tick(); tick();
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_load", LOAD, 0);
      check("idle_busy", BUSY, 0);
      check("idle_ready", WR_READY, 1);
    end
    check("idle_data", DATA, 0);

    // 2: single write, latency and one-cycle strobe
    WR_VALID = 1'b1; WR_ADDR = 5'd5; WR_DATA = 32'hDEADBEEF;
    check("single_ready", WR_READY, 1);
    tick();
    WR_VALID = 1'b0;
    check("single_busy", BUSY, 1);
    check("single_early", LOAD, 0);
    tick();
    check("single_load", LOAD, 32'h0000_0020);
    check("single_data", DATA, 32'hDEADBEEF);
    check("single_busy0", BUSY, 0);
    tick();
    check("single_off", LOAD, 0);
    check("single_hold", DATA, 32'hDEADBEEF);

    // 3: HOLD fills the buffer, then drains in order
    HOLD = 1'b1;
    WR_VALID = 1'b1; WR_ADDR = 5'd3; WR_DATA = 32'h1;
    tick();
    WR_ADDR = 5'd7; WR_DATA = 32'h2;
    tick();
    check("full_ready", WR_READY, 0);
    WR_ADDR = 5'd9; WR_DATA = 32'h3;
    tick(); tick();
    check("stall_ready", WR_READY, 0);
    check("stall_load", LOAD, 0);
    check("stall_busy", BUSY, 1);
    WR_VALID = 1'b0;
    HOLD = 1'b0;
    tick();
    check("drain1_load", LOAD, 32'h8);
    check("drain1_data", DATA, 32'h1);
    check("drain1_busy", BUSY, 1);
    tick();
    check("drain2_load", LOAD, 32'h80);
    check("drain2_data", DATA, 32'h2);
    check("drain2_busy", BUSY, 0);
    tick();
    check("drain_off", LOAD, 0);

    // 4: back-to-back stream of 8 writes (addr 10..17, data 100..107)
    for (int i = 0; i < 8; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR  = 5'(10 + i);
      WR_DATA  = 32'(100 + i);
      check("stream_ready", WR_READY, 1);
      tick();
      if (i > 0) begin
        check("stream_load", LOAD, 32'h1 << (9 + i));
        check("stream_data", DATA, 32'(99 + i));
      end
    end
    WR_VALID = 1'b0;
    tick();
    check("stream_last_load", LOAD, 32'h0002_0000);
    check("stream_last_data", DATA, 32'd107);
    tick();
    check("stream_off", LOAD, 0);
    check("stream_busy", BUSY, 0);

    // 5: write to register 0
`ifdef RF_WR_ZERO_PROTECT_EN
    exp_load = 32'h0;
    exp_data = 32'd107;
`else
    exp_load = 32'h1;
    exp_data = 32'h0000FFFF;
`endif
    WR_VALID = 1'b1; WR_ADDR = 5'd0; WR_DATA = 32'h0000FFFF;
    tick();
    WR_VALID = 1'b0;
    check("zero_busy", BUSY, 1);
    tick();
    check("zero_load", LOAD, exp_load);
    check("zero_data", DATA, exp_data);
    check("zero_busy0", BUSY, 0);

    // 6: asynchronous reset discards queued writes
    HOLD = 1'b1;
    WR_VALID = 1'b1; WR_ADDR = 5'd20; WR_DATA = 32'hAAAA;
    tick();
    WR_ADDR = 5'd21; WR_DATA = 32'hBBBB;
    tick();
    WR_VALID = 1'b0;
    check("q_busy", BUSY, 1);
    check("q_ready", WR_READY, 0);
    #2;
    RST = 1'b0;
    #1;
    check("arst_load", LOAD, 0);
    check("arst_busy", BUSY, 0);
    check("arst_ready", WR_READY, 1);
    check("arst_data", DATA, 0);
    tick();
    RST = 1'b1;
    HOLD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_load", LOAD, 0);
      check("post_rst_busy", BUSY, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
